// File: rtl/mips_avalon_arbiter.sv
// Purpose : shares one Avalon-MM slave between the MIPS instruction-fetch
//           port (read-only) and the data port, one transfer at a time,
//           round-robin when both request in the same IDLE cycle.
// Latency : 1 arbitration cycle (request in n -> avm_* strobe in n+1);
//           at least 2 cycles from request to completion; the bus is idle
//           for one cycle between transfers.
// Backpressure: each port sees its own combinational waitrequest; it drops
//           only in the slave's completion cycle of that port's grant.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr_*             fetch slave port (address, read, waitrequest, readdata)
//   data_*              data slave port (address, read, write, writedata,
//                       byteenable, waitrequest, readdata)
//   avm_*               shared master port towards the memory slave
module mips_avalon_arbiter #(
    parameter bit INIT_LAST_DATA = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] instr_address,
    input  logic        instr_read,
    output logic        instr_waitrequest,
    output logic [31:0] instr_readdata,

    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic        data_waitrequest,
    output logic [31:0] data_readdata,

    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_INSTR = 2'd1,
        GNT_DATA  = 2'd2
    } state_t;

    state_t      state;
    logic        last_data;      // 1: data port was served most recently
    logic [31:0] instr_rdata_q;  // last fetched word, held between fetches
    logic [31:0] data_rdata_q;   // last loaded word, held across writes

    logic i_req;
    logic d_req;
    logic grant_instr;
    logic grant_data;
    logic done_instr;
    logic done_data;

    assign i_req = instr_read;
    assign d_req = data_read | data_write;

    // Round-robin tie break: the port that was not served last wins.
    assign grant_instr = (state == IDLE) & i_req & (~d_req | last_data);
    assign grant_data  = (state == IDLE) & d_req & ~grant_instr;

    // A grant completes in the first cycle the slave releases waitrequest.
    assign done_instr = (state == GNT_INSTR) & ~avm_waitrequest;
    assign done_data  = (state == GNT_DATA)  & ~avm_waitrequest;

    // Waitrequests are combinational so a port that is not requesting never
    // stalls, and the owner sees the release in the same cycle as the slave.
    assign instr_waitrequest = i_req & ~done_instr;
    assign data_waitrequest  = d_req & ~done_data;

    // Read data bypasses the register in the completion cycle so the
    // requester can capture it on the edge where its waitrequest is low.
    assign instr_readdata = done_instr ? avm_readdata : instr_rdata_q;
    assign data_readdata  = (done_data & avm_read) ? avm_readdata : data_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_data      <= INIT_LAST_DATA;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            instr_rdata_q  <= '0;
            data_rdata_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_instr) begin
                        state          <= GNT_INSTR;
                        avm_address    <= instr_address;
                        avm_read       <= 1'b1;
                        avm_write      <= 1'b0;
                        avm_writedata  <= '0;
                        avm_byteenable <= 4'b1111;
                    end else if (grant_data) begin
                        state          <= GNT_DATA;
                        avm_address    <= data_address;
                        // Read and write together is illegal; the write wins.
                        avm_read       <= data_read & ~data_write;
                        avm_write      <= data_write;
                        avm_writedata  <= data_writedata;
                        avm_byteenable <= data_byteenable;
                    end
                end

                GNT_INSTR: begin
                    // Requester inputs are ignored here; the latched copy
                    // stays on the bus until the slave completes.
                    if (done_instr) begin
                        state         <= IDLE;
                        last_data     <= 1'b0;
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b0;
                        instr_rdata_q <= avm_readdata;
                    end
                end

                GNT_DATA: begin
                    if (done_data) begin
                        state     <= IDLE;
                        last_data <= 1'b1;
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        if (avm_read) begin
                            data_rdata_q <= avm_readdata;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    avm_read  <= 1'b0;
                    avm_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Purpose : randomized self-checking bench for mips_avalon_arbiter with a
//           memory slave model and a transaction-level reference model.
// Latency : one model step per clock; outputs sampled 1 ns after negedge.
// Backpressure: slave waitrequest randomized; requesters hold until released.
module tb_mips_avalon_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic        data_waitrequest;
    logic [31:0] data_readdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    mips_avalon_arbiter #(.INIT_LAST_DATA(1'b1)) dut (
        .clk               (clk),
        .rst               (rst),
        .instr_address     (instr_address),
        .instr_read        (instr_read),
        .instr_waitrequest (instr_waitrequest),
        .instr_readdata    (instr_readdata),
        .data_address      (data_address),
        .data_read         (data_read),
        .data_write        (data_write),
        .data_writedata    (data_writedata),
        .data_byteenable   (data_byteenable),
        .data_waitrequest  (data_waitrequest),
        .data_readdata     (data_readdata),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- slave memory model (16 words) ----------------
    logic [31:0] smem [16];
    assign avm_readdata = smem[avm_address[5:2]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (avm_write === 1'b1 && avm_waitrequest === 1'b0)
            smem[avm_address[5:2]] <= merge(smem[avm_address[5:2]], avm_writedata, avm_byteenable);
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [16];
    int          m_owner;   // 0 none, 1 instr transfer in flight, 2 data transfer
    bit          m_last;    // data was served most recently
    bit          m_valid;   // model meaningful (after first reset)
    logic [31:0] m_addr, m_wd, m_ird, m_drd;
    logic [3:0]  m_be;
    bit          m_rd, m_wr;
    bit          i_act, d_act;   // requester has an outstanding request
    int          n_grant_i, n_grant_d;

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'hBFC00000;
        a[5:2] = 4'($urandom_range(0, 15));
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    task automatic drive(input int req_pct);
        if (!i_act) begin
            instr_read = 1'b0;
            if ($urandom_range(0, 99) < req_pct) begin
                i_act = 1; instr_read = 1'b1; instr_address = rand_addr();
            end
        end else if (m_owner == 1 && $urandom_range(0, 99) < 30) begin
            instr_address = $urandom();   // must be ignored while granted
        end
        if (!d_act) begin
            data_read = 1'b0; data_write = 1'b0;
            if ($urandom_range(0, 99) < req_pct) begin
                int k;
                k = $urandom_range(0, 99);
                d_act = 1;
                data_address    = rand_addr();
                data_writedata  = $urandom();
                data_byteenable = 4'($urandom_range(0, 15));
                data_write      = (k < 50);
                data_read       = (k >= 45);   // 45..49: illegal read+write
            end
        end else if (m_owner == 2 && $urandom_range(0, 99) < 30) begin
            data_address   = $urandom();
            data_writedata = $urandom();
        end
    endtask

    task automatic cycle(input int req_pct, input int wait_pct, input bit do_rst);
        bit w, i_req, d_req, done;
        @(negedge clk);
        rst = do_rst;
        drive(req_pct);
        avm_waitrequest = do_rst ? 1'b1 : ($urandom_range(0, 99) < wait_pct);
        #1;
        w     = avm_waitrequest;
        i_req = instr_read;
        d_req = data_read | data_write;
        done  = (m_owner != 0) && !w;
        if (m_valid) begin
            chk("avm_read",  32'(avm_read),  32'(m_rd));
            chk("avm_write", 32'(avm_write), 32'(m_wr));
            chk("avm_addr",  avm_address,    m_addr);
            chk("avm_wdata", avm_writedata,  m_wd);
            chk("avm_be",    32'(avm_byteenable), 32'(m_be));
            chk("instr_wait", 32'(instr_waitrequest), 32'(i_req && !(m_owner == 1 && !w)));
            chk("data_wait",  32'(data_waitrequest),  32'(d_req && !(m_owner == 2 && !w)));
            chk("instr_rdata", instr_readdata,
                (m_owner == 1 && !w) ? ref_mem[m_addr[5:2]] : m_ird);
            chk("data_rdata", data_readdata,
                (m_owner == 2 && !w && m_rd) ? ref_mem[m_addr[5:2]] : m_drd);
        end
        // model the clock edge
        if (do_rst) begin
            m_valid = 1; m_owner = 0; m_last = 1;
            m_addr = '0; m_wd = '0; m_be = '0; m_rd = 0; m_wr = 0;
            m_ird = '0; m_drd = '0; i_act = 0; d_act = 0;
        end else if (m_owner == 0) begin
            if (i_req && (!d_req || m_last)) begin
                m_owner = 1; n_grant_i++;
                m_addr = instr_address; m_rd = 1; m_wr = 0; m_wd = '0; m_be = 4'hF;
            end else if (d_req) begin
                m_owner = 2; n_grant_d++;
                m_addr = data_address; m_wr = data_write; m_rd = data_read && !data_write;
                m_wd = data_writedata; m_be = data_byteenable;
            end
        end else if (done) begin
            if (m_owner == 1) begin m_ird = ref_mem[m_addr[5:2]]; i_act = 0; end
            else begin
                if (m_rd) m_drd = ref_mem[m_addr[5:2]];
                if (m_wr) ref_mem[m_addr[5:2]] = merge(ref_mem[m_addr[5:2]], m_wd, m_be);
                d_act = 0;
            end
            m_last = (m_owner == 2);
            m_owner = 0; m_rd = 0; m_wr = 0;
        end
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 16; i++) begin
            smem[i] = $urandom();
            ref_mem[i] = smem[i];
        end
        rst = 1'b1; instr_read = 0; instr_address = '0;
        data_read = 0; data_write = 0; data_address = '0;
        data_writedata = '0; data_byteenable = '0; avm_waitrequest = 1'b1;
        i_act = 0; d_act = 0; m_valid = 0; m_owner = 0;
        n_grant_i = 0; n_grant_d = 0;

        // reset; second reset cycle checks the reset state
        cycle(0, 0, 1);
        cycle(0, 0, 1);

        // simultaneous first requests: instr must be granted first
        cycle(100, 50, 0);
        chk("first_grant_instr", 32'(m_owner), 32'd1);
        chk("first_grant_rd",    32'(avm_read), 32'd0);

        // back-to-back saturation: grants must alternate
        for (int i = 0; i < 40; i++) cycle(100, 30, 0);
        chk("alternate_grants", 32'(n_grant_i - n_grant_d <= 1 && n_grant_d - n_grant_i <= 1), 32'd1);

        // long random mix with varying slave stall rates
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 100), (i < 1500) ? 40 : 80, 0);

        // drain outstanding requests then stay idle for 20 cycles
        for (int i = 0; i < 200 && (i_act || d_act); i++) cycle(0, 20, 0);
        chk("drained", 32'(i_act || d_act), 32'd0);
        for (int i = 0; i < 20; i++) cycle(0, 50, 0);

        // reset during an instruction grant with the slave stalled
        guard = 0;
        while (m_owner != 1 && guard < 100) begin
            cycle(60, 90, 0);
            guard++;
        end
        chk("midrst_reached_gnt_instr", 32'(m_owner), 32'd1);
        cycle(0, 100, 0);
        cycle(0, 100, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);
        chk("midrst_instr_rdata", instr_readdata, 32'd0);
        chk("midrst_data_rdata",  data_readdata,  32'd0);

        // traffic after the aborted transfer
        for (int i = 0; i < 300; i++) cycle(50, 40, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
